abc_run_encoder: RTL and testbench

Downstream consumer of the registered 1-bit `out` stream produced by the abc datapath. It run-length encodes that stream into {level, length} tokens. Tokens are buffered in a small FIFO and delivered to a monitor/logging stage over a valid/ready handshake. A sticky flag records any token lost to FIFO overflow.

---
 rtl/abc_run_encoder.sv | 145 ++++++++++++++
 tb/tb_abc_run_encoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/abc_run_encoder.sv
// ---------------------------------------------------------------------------
// abc_run_encoder
//
// Purpose:
//   Run-length encodes the registered 1-bit stream coming out of the abc
//   datapath into {level, length} tokens. Tokens queue in a small show-ahead
//   FIFO and are handed to a monitor/logging stage over valid/ready. A sticky
//   flag remembers whether any token was ever lost to a full FIFO.
//
// Ports:
//   clock      in   single clock, all state changes on the rising edge
//   reset      in   synchronous, active-high reset
//   in         in   sampled bit stream (abc `out`)
//   rl_valid   out  a token is available at the FIFO head
//   rl_ready   in   consumer takes the head token on this edge
//   rl_level   out  level of the head token (0 when no token is available)
//   rl_length  out  run length of the head token, 1..2^CNT_W-1 (0 when empty)
//   overflow   out  sticky: a token was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module abc_run_encoder #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in,
    output logic             rl_valid,
    input  logic             rl_ready,
    output logic             rl_level,
    output logic [CNT_W-1:0] rl_length,
    output logic             overflow
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] MAX_LEN  = '1;
    localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic             curLevel_q, curLevel_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q,    rdPtr_d;
    logic [PTR_W:0]   occ_q,      occ_d;
    logic             overflow_q, overflow_d;

    logic             memLevel_q  [DEPTH];
    logic [CNT_W-1:0] memLength_q [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic write;

    // Run tracker. The token being closed is always the current level and
    // count, both for a level change and for a saturated run, so only the
    // decision to push differs between those two cases. A saturated run
    // restarts at 1 rather than wrapping, so a length of 0 never appears.
    always_comb begin
        state_d    = state_q;
        curLevel_d = curLevel_q;
        count_d    = count_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                state_d    = RUN;
                curLevel_d = in;
                count_d    = CNT_W'(1);
            end
            default: begin
                if (in != curLevel_q) begin
                    push       = 1'b1;
                    curLevel_d = in;
                    count_d    = CNT_W'(1);
                end else if (count_q == MAX_LEN) begin
                    push    = 1'b1;
                    count_d = CNT_W'(1);
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        endcase
    end

    // FIFO bookkeeping. A pop on the same edge frees a slot, so a push into
    // a full FIFO is still kept when the consumer is taking the head; only a
    // push into a full FIFO with no pop is dropped and flagged.
    always_comb begin
        full       = (occ_q == FULL_OCC);
        pop        = rl_valid && rl_ready;
        write      = push && (!full || pop);
        overflow_d = overflow_q || (push && full && !pop);
        wrPtr_d    = write ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d    = pop   ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        case ({write, pop})
            2'b10:   occ_d = occ_q + (PTR_W + 1)'(1);
            2'b01:   occ_d = occ_q - (PTR_W + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control and pointer registers, cleared synchronously by reset. A run
    // that was partly accumulated when reset arrives is simply forgotten.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            curLevel_q <= 1'b0;
            count_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            curLevel_q <= curLevel_d;
            count_q    <= count_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // Token storage needs no reset: entries are only ever read while the
    // occupancy counter says they hold a valid token.
    always_ff @(posedge clock) begin
        if (write && !reset) begin
            memLevel_q[wrPtr_q]  <= curLevel_q;
            memLength_q[wrPtr_q] <= count_q;
        end
    end

    // Show-ahead head. Outputs are forced to zero while the FIFO is empty so
    // stale storage never leaks out, and everything here comes from
    // registers only, so `in` has no combinational path to the outputs.
    always_comb begin
        rl_valid  = (occ_q != '0);
        rl_level  = rl_valid && memLevel_q[rdPtr_q];
        rl_length = rl_valid ? memLength_q[rdPtr_q] : '0;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_abc_run_encoder.sv
// ---------------------------------------------------------------------------
// tb_abc_run_encoder
//
// Purpose:
//   Self-checking bench for abc_run_encoder with a narrow count field so run
//   saturation is reached quickly. Expected tokens come from a queue-based
//   reference model of the run-length rules.
// ---------------------------------------------------------------------------
module tb_abc_run_encoder;

    localparam int CNT_W  = 3;
    localparam int DEPTH  = 4;
    localparam int MAXLEN = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in = 1'b0;
    logic             rl_valid;
    logic             rl_ready = 1'b0;
    logic             rl_level;
    logic [CNT_W-1:0] rl_length;
    logic             overflow;

    int testCount = 0;
    int failCount = 0;

    // Reference model: an explicit queue of outstanding tokens plus the run
    // currently being measured, updated straight from the encoding rules.
    bit mRunning  = 1'b0;
    int mLevel    = 0;
    int mLen      = 0;
    bit mOverflow = 1'b0;
    bit mJustReset = 1'b0;
    int qLevel[$];
    int qLen[$];

    abc_run_encoder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .rl_valid  (rl_valid),
        .rl_ready  (rl_ready),
        .rl_level  (rl_level),
        .rl_length (rl_length),
        .overflow  (overflow)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Compares the DUT's visible state with the model after an edge.
    task automatic checkOutput(input string tag);
        logic             expValid;
        logic             expLevel;
        logic [CNT_W-1:0] expLength;
        expValid  = (qLen.size() > 0);
        expLevel  = expValid ? 1'(qLevel[0]) : 1'b0;
        expLength = expValid ? CNT_W'(qLen[0]) : '0;

        testCount++;
        assert (rl_valid === expValid) else begin
            failCount++;
            $error("FAIL %s rl_valid: observed %0b expected %0b", tag, rl_valid, expValid);
        end
        testCount++;
        assert (overflow === mOverflow) else begin
            failCount++;
            $error("FAIL %s overflow: observed %0b expected %0b", tag, overflow, mOverflow);
        end
        if (expValid || mJustReset) begin
            testCount++;
            assert (rl_level === expLevel) else begin
                failCount++;
                $error("FAIL %s rl_level: observed %0b expected %0b", tag, rl_level, expLevel);
            end
            testCount++;
            assert (rl_length === expLength) else begin
                failCount++;
                $error("FAIL %s rl_length: observed %0d expected %0d", tag, rl_length, expLength);
            end
        end
    endtask

    // Drives one edge worth of inputs, advances the model by the same edge,
    // then samples the DUT 1 time unit after the rising edge.
    task automatic applyStimulus(input logic inBit, input logic ready,
                                 input logic rst, input string tag);
        bit doPop;
        bit doPush;
        int tokLevel;
        int tokLen;
        in       = inBit;
        rl_ready = ready;
        reset    = rst;

        doPush   = 1'b0;
        tokLevel = 0;
        tokLen   = 0;
        if (rst) begin
            qLevel.delete();
            qLen.delete();
            mRunning   = 1'b0;
            mOverflow  = 1'b0;
            mJustReset = 1'b1;
        end else begin
            mJustReset = 1'b0;
            doPop = (qLen.size() > 0) && ready;
            if (!mRunning) begin
                mRunning = 1'b1;
                mLevel   = int'(inBit);
                mLen     = 1;
            end else if (int'(inBit) != mLevel) begin
                doPush   = 1'b1;
                tokLevel = mLevel;
                tokLen   = mLen;
                mLevel   = int'(inBit);
                mLen     = 1;
            end else if (mLen == MAXLEN) begin
                doPush   = 1'b1;
                tokLevel = mLevel;
                tokLen   = MAXLEN;
                mLen     = 1;
            end else begin
                mLen++;
            end
            if (doPop) begin
                void'(qLevel.pop_front());
                void'(qLen.pop_front());
            end
            if (doPush) begin
                if (qLen.size() < DEPTH) begin
                    qLevel.push_back(tokLevel);
                    qLen.push_back(tokLen);
                end else begin
                    mOverflow = 1'b1;
                end
            end
        end

        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic rBit;
        logic rReady;
        logic rRst;

        $display("[TB] starting abc_run_encoder bench, CNT_W=%0d DEPTH=%0d", CNT_W, DEPTH);

        // Reset for two cycles; outputs must be cleared.
        applyStimulus(1'b0, 1'b1, 1'b1, "reset0");
        applyStimulus(1'b0, 1'b1, 1'b1, "reset1");

        // Basic runs: 0,0,0,1,1,0 -> (0,3) after edge 4, (1,2) after edge 6.
        applyStimulus(1'b0, 1'b1, 1'b0, "basic1");
        applyStimulus(1'b0, 1'b1, 1'b0, "basic2");
        applyStimulus(1'b0, 1'b1, 1'b0, "basic3");
        applyStimulus(1'b1, 1'b1, 1'b0, "basic4");
        applyStimulus(1'b1, 1'b1, 1'b0, "basic5");
        applyStimulus(1'b0, 1'b1, 1'b0, "basic6");
        applyStimulus(1'b0, 1'b1, 1'b0, "basic7");

        // Saturation: ten ones split into (1,7) then (1,3).
        applyStimulus(1'b0, 1'b1, 1'b1, "satReset");
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, "satOnes");
        applyStimulus(1'b0, 1'b0, 1'b0, "satZero");
        applyStimulus(1'b0, 1'b1, 1'b0, "satPop1");
        applyStimulus(1'b0, 1'b1, 1'b0, "satPop2");

        // Overflow: toggling with no consumer fills the FIFO and drops extras.
        applyStimulus(1'b0, 1'b0, 1'b1, "ovfReset");
        for (int i = 0; i < 7; i++) applyStimulus(1'(i % 2), 1'b0, 1'b0, "ovfFill");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, "ovfDrain");

        // Full FIFO with a simultaneous pop: new token kept, no overflow.
        applyStimulus(1'b0, 1'b0, 1'b1, "fullReset");
        for (int i = 0; i < 5; i++) applyStimulus(1'(i % 2), 1'b0, 1'b0, "fullFill");
        applyStimulus(1'b1, 1'b1, 1'b0, "fullPushPop");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, "fullDrain");

        // Backpressure: head holds for five cycles, popped when ready rises.
        applyStimulus(1'b0, 1'b0, 1'b1, "bpReset");
        applyStimulus(1'b0, 1'b0, 1'b0, "bpRun");
        applyStimulus(1'b1, 1'b0, 1'b0, "bpPush");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, "bpHold");
        applyStimulus(1'b1, 1'b1, 1'b0, "bpPop");

        // Reset mid-run with tokens queued: all state discarded.
        applyStimulus(1'b0, 1'b0, 1'b1, "midReset0");
        applyStimulus(1'b0, 1'b0, 1'b0, "midRun0");
        applyStimulus(1'b1, 1'b0, 1'b0, "midRun1");
        applyStimulus(1'b0, 1'b0, 1'b0, "midRun2");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, "midOnes");
        applyStimulus(1'b1, 1'b0, 1'b1, "midReset");
        applyStimulus(1'b0, 1'b1, 1'b0, "midIdle");
        applyStimulus(1'b1, 1'b1, 1'b0, "midFirstPush");

        // Randomized traffic: bursty runs, bursty backpressure, rare resets.
        rBit   = 1'b0;
        rReady = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rBit = ~rBit;
            if ($urandom_range(0, 5) == 0) rReady = ~rReady;
            rRst = ($urandom_range(0, 299) == 0);
            applyStimulus(rBit, rReady, rRst, "random");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
